ceespu_memory: RTL and testbench
================================

# ceespu_memory

Memory-access stage of the ceespu pipeline, directly downstream of the execute stage. Accepts the execute stage's memory request (address, lane write-enables, replicated store data) together with its writeback control. Runs a req/ack transaction on the data-memory bus, stalling upstream while a transaction is in flight. Aligns and sign/zero-extends load data, then presents one registered writeback (register index, write enable, data) to the register file.

## Interface

Parameters:
- none

Ports:
- I_clk  in  1  clock, all state on rising edge
- I_rst  in  1  reset, asynchronous, active-low
- I_memE  in  1  instruction accesses memory
- I_memWe  in  4  byte-lane write enables; all zero means load
- I_memAddress  in  32  byte address from execute adder
- I_storeData  in  32  store data, already lane-replicated
- I_selMem  in  3  [1:0]: 0 word, 1 half, 2 byte, 3 reserved (treated as word); [2]: 1 zero-extend, 0 sign-extend
- I_selWb  in  2  writeback source: 0 ALU, 1 memory, 2 link (PC+1), 3 reserved (ALU)
- I_aluResult  in  32  ALU result
- I_PC  in  14  instruction PC
- I_regD  in  5  destination register
- I_we  in  1  register write request
- O_dmemReq  out  1  bus request, held until ack
- O_dmemAddr  out  32  bus address, word-aligned (bits [1:0] forced 0)
- O_dmemWe  out  4  bus lane enables, 0000 for loads
- O_dmemWdata  out  32  bus write data
- I_dmemAck  in  1  bus completion, one cycle
- I_dmemRdata  in  32  read data, valid in ack cycle
- O_busy  out  1  stall upstream; inputs ignored while high
- O_we  out  1  register-file write enable
- O_regD  out  5  register-file index
- O_wbData  out  32  register-file write data

## Operation

- FSM states are IDLE and WAIT.
- IDLE, I_memE=0:
  - Register the writeback at the next edge: O_we=I_we, O_regD=I_regD.
  - O_wbData by I_selWb: 0/3 → I_aluResult; 2 → {18'b0, I_PC+1}, with the 14-bit add wrapping; 1 → I_aluResult, because a load always has I_memE=1.
- IDLE, I_memE=1:
  - Latch address, lane enables, store data, selMem, selWb, regD, we, and the low address bits [1:0].
  - Go to WAIT.
  - O_we=0 at that edge, inserting a bubble.
- WAIT:
  - O_dmemReq=1; O_dmemAddr, O_dmemWe and O_dmemWdata come from the latches and stay stable until ack.
  - On I_dmemAck=1, go to IDLE at the next edge, and at that same edge register the writeback: O_we=latched we, O_regD=latched regD.
  - O_wbData = formatted load data when latched selWb=1, otherwise the source as in IDLE, using latched values.
  - Without ack, stay in WAIT with O_we=0.
- Load formatting of I_dmemRdata, with off = latched address[1:0]:
  - Word: data unchanged.
  - Half: off[0]=1 selects [31:16], off[0]=0 selects [15:0]. This lane rule matches execute's write-enable generation.
  - Byte: off selects byte 0..3, i.e. bits [8*off+7 : 8*off].
  - Extension: selMem[2]=0 sign-extends from the top bit of the selected field; selMem[2]=1 zero-fills.
- Stores: the writeback is still issued. O_we follows latched we, which is 0 for stores, so no register write happens.
- Reset (I_rst=0, any time, including mid-WAIT):
  - State goes to IDLE; O_we, O_regD, O_wbData and all latches go to 0.
  - O_dmemReq drops immediately, because it is a decode of state.
  - An ack arriving after reset release is ignored.
- I_dmemAck while in IDLE is ignored.
- Inputs are ignored while O_busy=1; upstream must hold its instruction.

## Timing

- O_busy = (state==WAIT), combinational, and it includes the ack cycle.
- O_dmemReq = (state==WAIT), combinational. O_dmemAddr, O_dmemWe and O_dmemWdata are register outputs.
- Non-memory instruction: presented in cycle N, writeback outputs valid after edge N+1. Throughput is 1 per cycle.
- Memory instruction: presented in cycle N, request visible in cycle N+1.
  - Ack in cycle N+k (k≥1) gives writeback valid after edge N+k+1.
  - The next instruction is accepted at edge N+k+2.
  - Minimum is 2 cycles to writeback and 3 cycles of occupancy.
- O_we is high for exactly one cycle per writeback instruction.
- Reset values: O_dmemReq=0, O_dmemAddr=0, O_dmemWe=0, O_dmemWdata=0, O_busy=0, O_we=0, O_regD=0, O_wbData=0.

## Test plan

- **ALU pass-through:** I_selWb=0, I_aluResult=0x12345678, I_regD=3, I_we=1 → after one edge, O_we=1, O_regD=3, O_wbData=0x12345678; O_busy never asserts.
- **Link with wrap:** I_selWb=2, I_PC=0x3FFF, I_we=1 → O_wbData=0x00000000.
- **Signed byte load with 2-cycle wait:**
  - Stimulus: I_memE=1, I_memWe=0, I_memAddress=0x103, I_selMem=3'b010; ack asserted in the 3rd cycle of WAIT with I_dmemRdata=0x80FF0011.
  - Expect during WAIT: O_dmemAddr=0x100, O_dmemReq=1 and O_busy=1 for 3 cycles.
  - Expect at writeback: O_wbData=0xFFFFFF80, O_we=1 for one cycle.
- **Unsigned upper-half load:** address off[0]=1, I_selMem=3'b101, rdata=0xBEEF1234 → O_wbData=0x0000BEEF. With I_selMem=3'b001 → O_wbData=0xFFFFBEEF.
- **Store:**
  - Stimulus: I_memWe=4'b0100, I_storeData=0xAAAAAAAA, I_we=0, immediate ack.
  - Expect: O_dmemWe=0100 and O_dmemWdata=0xAAAAAAAA held through ack; O_we stays 0; the next instruction is accepted 3 edges after the store was presented.
- **Reset mid-WAIT:** pull I_rst low during WAIT → O_dmemReq and O_busy=0 immediately, outputs 0. After release, a stray I_dmemAck produces no writeback.

Source files
------------

// File: rtl/ceespu_memory.sv
// rtl/ceespu_memory.sv - ceespu memory-access stage with req/ack data bus and load formatting
//
// Takes the execute stage's memory request and writeback control. Non-memory
// instructions pass straight to a registered writeback. Memory instructions
// hold the pipeline (O_busy) while a single req/ack bus transaction runs. Load
// data is then aligned and extended before the writeback is registered.
//
// Ports:
//   I_clk, I_rst         clock (rising edge), asynchronous active-low reset
//   I_memE .. I_we       execute-stage request and writeback control
//   O_dmemReq/Addr/We/Wdata, I_dmemAck/Rdata   data-memory bus
//   O_busy               upstream stall, high for the whole transaction
//   O_we, O_regD, O_wbData   registered register-file writeback
module ceespu_memory (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_memE,
  input  logic [3:0]  I_memWe,
  input  logic [31:0] I_memAddress,
  input  logic [31:0] I_storeData,
  input  logic [2:0]  I_selMem,
  input  logic [1:0]  I_selWb,
  input  logic [31:0] I_aluResult,
  input  logic [13:0] I_PC,
  input  logic [4:0]  I_regD,
  input  logic        I_we,
  output logic        O_dmemReq,
  output logic [31:0] O_dmemAddr,
  output logic [3:0]  O_dmemWe,
  output logic [31:0] O_dmemWdata,
  input  logic        I_dmemAck,
  input  logic [31:0] I_dmemRdata,
  output logic        O_busy,
  output logic        O_we,
  output logic [4:0]  O_regD,
  output logic [31:0] O_wbData
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [2:0]  sel_mem_q;
  logic [1:0]  sel_wb_q;
  logic [1:0]  off_q;
  logic [4:0]  reg_d_q;
  logic        we_q;
  logic [31:0] alu_q;
  logic [13:0] pc_q;

  // Extracts the addressed field and extends it. The half-word lane choice
  // uses off[0], mirroring how execute generates half-word write enables.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                           input logic [2:0]  sel,
                                           input logic [1:0]  off);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic        zext;
    logic [31:0] res;
    zext = sel[2];
    half = off[0] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (sel[1:0])
      2'd1:    res = {{16{~zext & half[15]}}, half};
      2'd2:    res = {{24{~zext & byte_v[7]}}, byte_v};
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Non-load writeback source; the link value wraps within the 14-bit PC.
  function automatic logic [31:0] wb_src(input logic [1:0]  sel_wb,
                                         input logic [31:0] alu,
                                         input logic [13:0] pc);
    logic [13:0] link;
    link = pc + 14'd1;
    return (sel_wb == 2'd2) ? {18'b0, link} : alu;
  endfunction

  assign O_busy    = (state == S_WAIT);
  assign O_dmemReq = (state == S_WAIT);

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state       <= S_IDLE;
      O_dmemAddr  <= '0;
      O_dmemWe    <= '0;
      O_dmemWdata <= '0;
      sel_mem_q   <= '0;
      sel_wb_q    <= '0;
      off_q       <= '0;
      reg_d_q     <= '0;
      we_q        <= 1'b0;
      alu_q       <= '0;
      pc_q        <= '0;
      O_we        <= 1'b0;
      O_regD      <= '0;
      O_wbData    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_memE) begin
            O_dmemAddr  <= {I_memAddress[31:2], 2'b00};
            O_dmemWe    <= I_memWe;
            O_dmemWdata <= I_storeData;
            sel_mem_q   <= I_selMem;
            sel_wb_q    <= I_selWb;
            off_q       <= I_memAddress[1:0];
            reg_d_q     <= I_regD;
            we_q        <= I_we;
            alu_q       <= I_aluResult;
            pc_q        <= I_PC;
            O_we        <= 1'b0;
            state       <= S_WAIT;
          end else begin
            O_we     <= I_we;
            O_regD   <= I_regD;
            O_wbData <= wb_src(I_selWb, I_aluResult, I_PC);
          end
        end
        S_WAIT: begin
          if (I_dmemAck) begin
            O_we     <= we_q;
            O_regD   <= reg_d_q;
            O_wbData <= (sel_wb_q == 2'd1) ? fmt_load(I_dmemRdata, sel_mem_q, off_q)
                                           : wb_src(sel_wb_q, alu_q, pc_q);
            state    <= S_IDLE;
          end else begin
            O_we <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_memory.sv
// tb/tb_ceespu_memory.sv - self-checking bench for ceespu_memory
module tb_ceespu_memory;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic        I_memE = 1'b0;
  logic [3:0]  I_memWe = '0;
  logic [31:0] I_memAddress = '0;
  logic [31:0] I_storeData = '0;
  logic [2:0]  I_selMem = '0;
  logic [1:0]  I_selWb = '0;
  logic [31:0] I_aluResult = '0;
  logic [13:0] I_PC = '0;
  logic [4:0]  I_regD = '0;
  logic        I_we = 1'b0;
  logic        O_dmemReq;
  logic [31:0] O_dmemAddr;
  logic [3:0]  O_dmemWe;
  logic [31:0] O_dmemWdata;
  logic        I_dmemAck = 1'b0;
  logic [31:0] I_dmemRdata = '0;
  logic        O_busy;
  logic        O_we;
  logic [4:0]  O_regD;
  logic [31:0] O_wbData;

  int errors = 0;
  int checks = 0;

  ceespu_memory dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_memE(I_memE), .I_memWe(I_memWe),
    .I_memAddress(I_memAddress), .I_storeData(I_storeData), .I_selMem(I_selMem),
    .I_selWb(I_selWb), .I_aluResult(I_aluResult), .I_PC(I_PC), .I_regD(I_regD),
    .I_we(I_we), .O_dmemReq(O_dmemReq), .O_dmemAddr(O_dmemAddr), .O_dmemWe(O_dmemWe),
    .O_dmemWdata(O_dmemWdata), .I_dmemAck(I_dmemAck), .I_dmemRdata(I_dmemRdata),
    .O_busy(O_busy), .O_we(O_we), .O_regD(O_regD), .O_wbData(O_wbData)
  );

  always #5 I_clk = ~I_clk;

  // Reference: shift the addressed field down, mask to its width, extend.
  function automatic logic [31:0] model_load(input logic [31:0] rdata,
                                             input logic [2:0] sel, input logic [1:0] off);
    int width;
    int shift;
    logic [31:0] v;
    logic [31:0] mask;
    width = (sel[1:0] == 2'd1) ? 16 : (sel[1:0] == 2'd2) ? 8 : 32;
    shift = (width == 16) ? (off[0] ? 16 : 0) : (width == 8) ? 8 * int'(off) : 0;
    v = rdata >> shift;
    if (width < 32) begin
      mask = (32'd1 << width) - 32'd1;
      v = v & mask;
      if (!sel[2] && v[width-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_src(input logic [1:0] sel_wb,
                                            input logic [31:0] alu, input logic [13:0] pc);
    int link;
    link = (int'(pc) + 1) % 16384;
    return (sel_wb == 2'd2) ? 32'(link) : alu;
  endfunction

  // Presents a non-memory instruction and checks the writeback one edge later.
  task automatic do_alu(input logic [1:0] sel_wb, input logic [31:0] alu,
                        input logic [13:0] pc, input logic [4:0] regd, input logic we);
    logic [31:0] exp;
    exp = model_src(sel_wb, alu, pc);
    I_memE = 1'b0; I_selWb = sel_wb; I_aluResult = alu; I_PC = pc;
    I_regD = regd; I_we = we;
    @(negedge I_clk);
    checks++;
    if (O_we !== we || O_regD !== regd || O_wbData !== exp || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb: got we=%b rd=%0d data=%h busy=%b expected we=%b rd=%0d data=%h busy=0",
               O_we, O_regD, O_wbData, O_busy, we, regd, exp);
    end
  endtask

  // Presents a memory instruction, acks in WAIT cycle k, checks bus and writeback.
  task automatic do_mem(input logic [3:0] lanes, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [2:0] sel_mem,
                        input logic [1:0] sel_wb, input logic [31:0] alu,
                        input logic [13:0] pc, input logic [4:0] regd, input logic we,
                        input int k, input logic [31:0] rdata);
    logic [31:0] exp;
    exp = (sel_wb == 2'd1) ? model_load(rdata, sel_mem, addr[1:0]) : model_src(sel_wb, alu, pc);
    I_memE = 1'b1; I_memWe = lanes; I_memAddress = addr; I_storeData = sdata;
    I_selMem = sel_mem; I_selWb = sel_wb; I_aluResult = alu; I_PC = pc;
    I_regD = regd; I_we = we;
    @(negedge I_clk);
    I_memE = 1'b0; I_memAddress = $urandom; I_memWe = 4'($urandom); I_storeData = $urandom;
    for (int i = 1; i <= k; i++) begin
      checks++;
      if (O_busy !== 1'b1 || O_dmemReq !== 1'b1 || O_we !== 1'b0 ||
          O_dmemAddr !== {addr[31:2], 2'b00} || O_dmemWe !== lanes || O_dmemWdata !== sdata) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got busy=%b req=%b we=%b addr=%h lanes=%b wdata=%h expected 1 1 0 %h %b %h",
                 i, O_busy, O_dmemReq, O_we, O_dmemAddr, O_dmemWe, O_dmemWdata,
                 {addr[31:2], 2'b00}, lanes, sdata);
      end
      if (i == k) begin
        I_dmemAck = 1'b1; I_dmemRdata = rdata;
      end
      @(negedge I_clk);
    end
    I_dmemAck = 1'b0; I_dmemRdata = $urandom;
    checks++;
    if (O_we !== we || O_regD !== regd || O_wbData !== exp || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL mem_wb: got we=%b rd=%0d data=%h busy=%b expected we=%b rd=%0d data=%h busy=0",
               O_we, O_regD, O_wbData, O_busy, we, regd, exp);
    end
    I_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge I_clk);
    checks++;
    if (O_dmemReq !== 1'b0 || O_dmemAddr !== 32'd0 || O_dmemWe !== 4'd0 || O_dmemWdata !== 32'd0 ||
        O_busy !== 1'b0 || O_we !== 1'b0 || O_regD !== 5'd0 || O_wbData !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h lanes=%b wdata=%h busy=%b we=%b rd=%0d data=%h expected all 0",
               O_dmemReq, O_dmemAddr, O_dmemWe, O_dmemWdata, O_busy, O_we, O_regD, O_wbData);
    end
    I_rst = 1'b1;
  endtask

  task automatic test_alu_link();
    do_alu(2'd0, 32'h12345678, 14'd5, 5'd3, 1'b1);
    do_alu(2'd2, 32'hDEADBEEF, 14'h3FFF, 5'd7, 1'b1);
    do_alu(2'd3, 32'hCAFEF00D, 14'd9, 5'd9, 1'b1);
    do_alu(2'd2, 32'h0, 14'h0123, 5'd31, 1'b0);
  endtask

  task automatic test_loads();
    do_mem(4'b0000, 32'h103, 32'h0, 3'b010, 2'd1, 32'h0, 14'd0, 5'd4, 1'b1, 3, 32'h80FF0011);
    I_memE = 1'b0; I_we = 1'b0;
    @(negedge I_clk);
    checks++;
    if (O_we !== 1'b0) begin
      errors++;
      $display("FAIL we_one_cycle: got %b expected 0", O_we);
    end
    do_mem(4'b0000, 32'h201, 32'h0, 3'b101, 2'd1, 32'h0, 14'd0, 5'd5, 1'b1, 1, 32'hBEEF1234);
    do_mem(4'b0000, 32'h201, 32'h0, 3'b001, 2'd1, 32'h0, 14'd0, 5'd6, 1'b1, 2, 32'hBEEF1234);
  endtask

  task automatic test_store();
    do_mem(4'b0100, 32'h40A, 32'hAAAAAAAA, 3'b010, 2'd0, 32'h1111, 14'd0, 5'd8, 1'b0, 1, 32'h0);
    do_alu(2'd0, 32'h55AA55AA, 14'd0, 5'd10, 1'b1);
  endtask

  task automatic test_stray_ack();
    I_memE = 1'b0; I_we = 1'b0; I_dmemAck = 1'b1; I_dmemRdata = 32'hFFFFFFFF;
    @(negedge I_clk);
    I_dmemAck = 1'b0;
    checks++;
    if (O_busy !== 1'b0 || O_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: got busy=%b we=%b expected 0 0", O_busy, O_we);
    end
  endtask

  task automatic test_reset_mid_wait();
    I_memE = 1'b1; I_memWe = 4'b0000; I_memAddress = 32'h888; I_selMem = 3'b000;
    I_selWb = 2'd1; I_regD = 5'd12; I_we = 1'b1;
    @(negedge I_clk);
    I_memE = 1'b0;
    I_rst = 1'b0;
    #1;
    checks++;
    if (O_dmemReq !== 1'b0 || O_busy !== 1'b0 || O_we !== 1'b0 || O_wbData !== 32'd0 ||
        O_regD !== 5'd0 || O_dmemAddr !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: got req=%b busy=%b we=%b data=%h rd=%0d addr=%h expected all 0",
               O_dmemReq, O_busy, O_we, O_wbData, O_regD, O_dmemAddr);
    end
    @(negedge I_clk);
    I_rst = 1'b1; I_we = 1'b0;
    @(negedge I_clk);
    I_dmemAck = 1'b1; I_dmemRdata = 32'h12345678;
    @(negedge I_clk);
    I_dmemAck = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (O_we !== 1'b0 || O_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_ack[%0d]: got we=%b busy=%b expected 0 0", i, O_we, O_busy);
      end
      @(negedge I_clk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_alu(2'($urandom_range(0, 3) == 2 ? 0 : $urandom_range(0, 3)), $urandom,
                  14'($urandom), 5'($urandom), 1'($urandom));
        1: do_alu(2'd2, $urandom, 14'($urandom), 5'($urandom), 1'($urandom));
        2: do_mem(4'b0000, $urandom, $urandom, 3'($urandom), 2'd1, $urandom, 14'($urandom),
                  5'($urandom), 1'b1, $urandom_range(1, 3), $urandom);
        default: do_mem(4'($urandom_range(1, 15)), $urandom, $urandom, 3'($urandom),
                        ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0, $urandom, 14'($urandom),
                        5'($urandom), 1'b0, $urandom_range(1, 3), $urandom);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu_link();
    test_loads();
    test_store();
    test_stray_ack();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
